mon_packet_tx: RTL and testbench

// - Host-side serial transmitter for the NeXT monitor link: serializes 40-bit packets onto the to_mon line.
// - Drives to_mon in the same framing the soundbox receiver expects.
// - Use 1: host emulator in the bench, driving the soundbox path.
// - Use 2: loopback self-test, with to_mon wired back to the receiver.

---
 rtl/mon_packet_tx_if.sv | 33 +++
 rtl/mon_packet_tx.sv | 174 +++++++++++++++++
 tb/tb_mon_packet_tx.sv | 439 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mon_packet_tx_if.sv
// Handshake and line signals of the NeXT monitor-link host transmitter.
// The producer (host side) uses the master modport; mon_packet_tx uses slave.
//
// Handshake: a packet transfers on a rising edge where tx_valid && tx_ready
// are both high. tx_ready is high only while the transmitter is idle.
// tx_valid seen while tx_ready is low is ignored, not queued, so the producer
// holds tx_valid and tx_data until it sees tx_ready.
interface mon_packet_tx_if;
  logic [39:0] tx_data;   // [39:32] opcode, [31:0] payload, sent MSB first
  logic        tx_valid;
  logic        tx_ready;
  logic        to_mon;    // serial line, idles high
  logic        busy;
  logic        tx_done;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  to_mon,
    input  busy,
    input  tx_done
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output to_mon,
    output busy,
    output tx_done
  );
endinterface

// File: rtl/mon_packet_tx.sv
// mon_packet_tx: host-side serial transmitter for the NeXT monitor link.
// Sends a 40-bit packet on to_mon as: one low start bit, 40 data bits MSB
// first, an optional even-parity bit, then GUARD_BITS bit-times of high line.
// Every bit lasts exactly BIT_CLKS mon_clk cycles. All outputs are flops.
//
// Optional feature: define MON_TX_PARITY_EN to append an even-parity bit
// (XOR of the 40 latched bits) after the last data bit. Without the macro
// there is no parity state and no parity logic.
//
// Parameter limits: BIT_CLKS >= 2, GUARD_BITS >= 1 (and <= 64),
// 2**W > BIT_CLKS.
module mon_packet_tx #(
  parameter int BIT_CLKS   = 50,
  parameter int GUARD_BITS = 2,
  parameter int W          = 6
) (
  input  logic           mon_clk,
  input  logic           reset,
  mon_packet_tx_if.slave bus,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef MON_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_GUARD  = 3'd4
  } state_t;

  // Counter terminal values. CNT_PRE marks the cycle before the last one of
  // a bit-time, used so the registered tx_done lands on the final cycle.
  localparam logic [W-1:0] CNT_LAST   = W'(BIT_CLKS - 1);
  localparam logic [W-1:0] CNT_PRE    = W'(BIT_CLKS - 2);
  localparam logic [W-1:0] CNT_ONE    = {{(W-1){1'b0}}, 1'b1};
  localparam logic [5:0]   LAST_BIT   = 6'd39;
  localparam logic [5:0]   GUARD_LAST = 6'(GUARD_BITS - 1);

  state_t        state;
  logic [W-1:0]  clk_cnt;   // cycle within the current bit-time
  logic [5:0]    bit_idx;   // data bit 0..39, reused as guard bit-time index
  logic [39:0]   shreg;     // latched packet, shifted left per data bit
  logic          to_mon_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
`ifdef MON_TX_PARITY_EN
  logic          parity_q;  // even parity of the latched packet
`endif

  assign bus.to_mon   = to_mon_q;
  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;
  assign bus.tx_done  = done_q;
  assign state_dbg    = state;

  // Transmit FSM: every output is registered and set for the state being
  // entered, so the line changes exactly on bit boundaries.
  always_ff @(posedge mon_clk) begin
    if (reset) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      to_mon_q <= 1'b1;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MON_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          // ready_q is already high here except on the first cycle after
          // reset, which keeps a packet from starting in that cycle.
          to_mon_q <= 1'b1;
          busy_q   <= 1'b0;
          ready_q  <= 1'b1;
          if (bus.tx_valid && ready_q) begin
            shreg    <= bus.tx_data;
`ifdef MON_TX_PARITY_EN
            parity_q <= ^bus.tx_data;
`endif
            clk_cnt  <= '0;
            bit_idx  <= '0;
            to_mon_q <= 1'b0;
            busy_q   <= 1'b1;
            ready_q  <= 1'b0;
            state    <= S_START;
          end
        end

        S_START: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt  <= '0;
            to_mon_q <= shreg[39];
            state    <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end

        S_DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              bit_idx  <= '0;
`ifdef MON_TX_PARITY_EN
              to_mon_q <= parity_q;
              state    <= S_PARITY;
`else
              to_mon_q <= 1'b1;
              state    <= S_GUARD;
`endif
            end else begin
              // Next bit is the one below the current MSB.
              bit_idx  <= bit_idx + 6'd1;
              shreg    <= {shreg[38:0], 1'b0};
              to_mon_q <= shreg[38];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end

`ifdef MON_TX_PARITY_EN
        S_PARITY: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt  <= '0;
            to_mon_q <= 1'b1;
            state    <= S_GUARD;
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end
`endif

        S_GUARD: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == GUARD_LAST) begin
              bit_idx <= '0;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
              state   <= S_IDLE;
            end else begin
              bit_idx <= bit_idx + 6'd1;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
          // Raised one cycle early so the flop shows it on the last cycle.
          if (clk_cnt == CNT_PRE && bit_idx == GUARD_LAST) begin
            done_q <= 1'b1;
          end
        end

        default: begin
          to_mon_q <= 1'b1;
          busy_q   <= 1'b0;
          ready_q  <= 1'b0;
          clk_cnt  <= '0;
          bit_idx  <= '0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mon_packet_tx.sv
// Directed bench for mon_packet_tx with BIT_CLKS=4, GUARD_BITS=2.
// Cycle k=1 is the first cycle after the handshake edge; the line model
// below derives the expected level of to_mon for every k.
`timescale 1ns/1ps
module tb_mon_packet_tx;
  localparam int BC = 4;
  localparam int GB = 2;
  localparam int CW = 3;
`ifdef MON_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int T    = (1 + 40 + P + GB) * BC;  // packet length in cycles
  localparam int MAXC = 400;

  // ---------------- clock / reset ----------------
  logic       mon_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [2:0] state_dbg;

  mon_packet_tx_if bus();

  mon_packet_tx #(.BIT_CLKS(BC), .GUARD_BITS(GB), .W(CW)) dut (
    .mon_clk   (mon_clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  always #5 mon_clk = ~mon_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  int tests_run    = 0;
  int tests_failed = 0;

  // Captured samples, index = cycle number k.
  logic w_q [0:MAXC];
  logic d_q [0:MAXC];
  logic b_q [0:MAXC];
  logic r_q [0:MAXC];

  // ---------------- model ----------------
  function automatic logic exp_line(input logic [39:0] d, input int k);
    int b;
    if (k < 1) return 1'b1;
    if (k <= BC) return 1'b0;
    b = (k - BC - 1) / BC;
    if (b < 40) return d[39 - b];
    if (P == 1 && b == 40) return ^d;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge mon_clk);
    #1;
  endtask

  // Presents d with tx_valid high, waits for tx_ready, then crosses the
  // handshake edge. On return we are in cycle 1 and tx_valid is still high.
  task automatic start_pkt(input logic [39:0] d, output bit timed_out);
    int n;
    n = 0;
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    while (bus.tx_ready !== 1'b1 && n < 600) begin
      step();
      n++;
    end
    timed_out = (bus.tx_ready !== 1'b1);
    step();
  endtask

  // Records cycles 1..n. tx_valid drops after cycle drop_at; at pulse_at
  // new data and a one-cycle tx_valid pulse are applied.
  task automatic capture(input int n, input int drop_at, input int pulse_at,
                         input logic [39:0] pulse_data);
    for (int k = 1; k <= n; k++) begin
      w_q[k] = bus.to_mon;
      d_q[k] = bus.tx_done;
      b_q[k] = bus.busy;
      r_q[k] = bus.tx_ready;
      if (k == drop_at) bus.tx_valid = 1'b0;
      if (k == pulse_at) begin
        bus.tx_data  = pulse_data;
        bus.tx_valid = 1'b1;
      end
      if (k == pulse_at + 1) bus.tx_valid = 1'b0;
      if (k < n) step();
    end
  endtask

  task automatic count_wire(input logic [39:0] d, input int off, input int lo,
                            input int hi, output int bad, output int first);
    bad = 0;
    first = -1;
    for (int k = lo; k <= hi; k++) begin
      if (w_q[k] !== exp_line(d, k - off)) begin
        bad++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic count_done(input int lo, input int hi, output int cnt, output int last_at);
    cnt = 0;
    last_at = -1;
    for (int k = lo; k <= hi; k++) begin
      if (d_q[k] === 1'b1) begin
        cnt++;
        last_at = k;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset        = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = 40'hC3_8000_0001;
    for (int i = 0; i < 3; i++) begin
      step();
      tests_run++;
      if (bus.to_mon !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_to_mon[%0d]: got %b, expected 1", i, bus.to_mon);
      end
      tests_run++;
      if (bus.busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_busy[%0d]: got %b, expected 0", i, bus.busy);
      end
      tests_run++;
      if (bus.tx_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_ready[%0d]: got %b, expected 0", i, bus.tx_ready);
      end
    end
    tests_run++;
    if (state_dbg !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, expected 0", state_dbg);
    end
    reset        = 1'b0;
    bus.tx_valid = 1'b0;
    step();
    tests_run++;
    if (bus.tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_ready: got %b, expected 1", bus.tx_ready);
    end
    tests_run++;
    if (bus.busy !== 1'b0 || bus.to_mon !== 1'b1) begin
      tests_failed++;
      $display("FAIL release_idle: got busy=%b to_mon=%b, expected busy=0 to_mon=1",
               bus.busy, bus.to_mon);
    end
  endtask

  task automatic test_single();
    logic [39:0] d;
    logic [9:0]  head;
    bit to;
    int bad, first, cnt, at;
    d    = 40'hC3_8000_0001;
    head = 10'b1100001110;
    start_pkt(d, to);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 40'hFF_FFFF_FFFF;  // changes after the handshake must not show
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL single_ready_timeout: got no tx_ready, expected tx_ready");
    end
    capture(T + 1, 0, -5, '0);

    bad = 0;
    for (int k = 1; k <= BC; k++) if (w_q[k] !== 1'b0) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL single_start_bit: got %0d high cycles in 1..4, expected 0", bad);
    end

    bad = 0;
    for (int i = 0; i < 10; i++)
      for (int j = 0; j < BC; j++)
        if (w_q[5 + BC*i + j] !== head[9 - i]) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL single_head_bits: got %0d wrong cycles, expected 0 (1,1,0,0,0,0,1,1,1,0)", bad);
    end

    bad = 0;
    for (int k = 161; k <= 164; k++) if (w_q[k] !== 1'b1) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL single_last_bit: got %0d low cycles in 161..164, expected 0", bad);
    end

    count_wire(d, 0, 1, T + 1, bad, first);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL single_wire: got %0d bad cycles (first %0d), expected 0", bad, first);
    end

    count_done(1, T + 1, cnt, at);
    tests_run++;
    if (cnt !== 1 || at !== T) begin
      tests_failed++;
      $display("FAIL single_done: got count=%0d at=%0d, expected count=1 at=%0d", cnt, at, T);
    end

    bad = 0;
    for (int k = 1; k <= T; k++) if (b_q[k] !== 1'b1 || r_q[k] !== 1'b0) bad++;
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL single_busy_ready: got %0d bad cycles, expected 0", bad);
    end

    tests_run++;
    if (r_q[T + 1] !== 1'b1 || b_q[T + 1] !== 1'b0 || d_q[T + 1] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_idle_after: got ready=%b busy=%b done=%b, expected 1 0 0",
               r_q[T + 1], b_q[T + 1], d_q[T + 1]);
    end
  endtask

  task automatic test_back_to_back();
    logic [39:0] a, b;
    bit to;
    int bad, first, cnt, at;
    a = 40'h12_3456_789A;
    b = 40'hE7_0F0F_5A5A;
    start_pkt(a, to);
    bus.tx_data = b;  // tx_valid stays high
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL b2b_ready_timeout: got no tx_ready, expected tx_ready");
    end
    capture(2*T + 1, T + 2, -5, '0);

    count_wire(a, 0, 1, T, bad, first);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL b2b_wire_a: got %0d bad cycles (first %0d), expected 0", bad, first);
    end

    tests_run++;
    if (w_q[T + 1] !== 1'b1 || r_q[T + 1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_gap: got to_mon=%b ready=%b, expected 1 1", w_q[T + 1], r_q[T + 1]);
    end

    count_wire(b, T + 1, T + 2, 2*T + 1, bad, first);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL b2b_wire_b: got %0d bad cycles (first %0d), expected 0", bad, first);
    end

    tests_run++;
    if (d_q[T] !== 1'b1 || w_q[T + 2] !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_restart: got done@%0d=%b start@%0d=%b, expected 1 0",
               T, d_q[T], T + 2, w_q[T + 2]);
    end

    count_done(1, 2*T + 1, cnt, at);
    tests_run++;
    if (cnt !== 2 || at !== 2*T + 1) begin
      tests_failed++;
      $display("FAIL b2b_done: got count=%0d last=%0d, expected count=2 last=%0d", cnt, at, 2*T + 1);
    end
  endtask

  task automatic test_ignore_busy();
    logic [39:0] d;
    bit to;
    int bad, first, cnt, at;
    d = 40'h96_0F0F_A5A5;
    start_pkt(d, to);
    bus.tx_valid = 1'b0;
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL ignore_ready_timeout: got no tx_ready, expected tx_ready");
    end
    capture(T + 3, 0, 60, ~d);

    count_wire(d, 0, 1, T + 3, bad, first);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL ignore_wire: got %0d bad cycles (first %0d), expected 0", bad, first);
    end

    count_done(1, T + 3, cnt, at);
    tests_run++;
    if (cnt !== 1 || at !== T) begin
      tests_failed++;
      $display("FAIL ignore_done: got count=%0d at=%0d, expected count=1 at=%0d", cnt, at, T);
    end

    tests_run++;
    if (b_q[T + 2] !== 1'b0 || b_q[T + 3] !== 1'b0) begin
      tests_failed++;
      $display("FAIL ignore_no_queue: got busy=%b%b, expected 00", b_q[T + 2], b_q[T + 3]);
    end
  endtask

  task automatic test_mid_reset();
    logic [39:0] e, f;
    bit to;
    int bad, first, cnt, at, seen;
    e = 40'h5A_1234_ABCD;
    f = 40'hA5_8001_0003;
    start_pkt(e, to);
    bus.tx_valid = 1'b0;
    tests_run++;
    if (to) begin
      tests_failed++;
      $display("FAIL midrst_ready_timeout: got no tx_ready, expected tx_ready");
    end
    capture(86, 0, -5, '0);  // cycle 86 lies in data bit 20 (cycles 85..88)

    count_wire(e, 0, 1, 86, bad, first);
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL midrst_partial: got %0d bad cycles (first %0d), expected 0", bad, first);
    end

    reset = 1'b1;
    step();
    tests_run++;
    if (bus.to_mon !== 1'b1 || bus.busy !== 1'b0 || bus.tx_ready !== 1'b0 || state_dbg !== 3'd0) begin
      tests_failed++;
      $display("FAIL midrst_abort: got to_mon=%b busy=%b ready=%b state=%0d, expected 1 0 0 0",
               bus.to_mon, bus.busy, bus.tx_ready, state_dbg);
    end
    seen = (bus.tx_done === 1'b1) ? 1 : 0;
    step();
    reset = 1'b0;
    step();
    tests_run++;
    if (bus.tx_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL midrst_release_ready: got %b, expected 1", bus.tx_ready);
    end
    for (int k = 0; k < 100; k++) begin
      if (bus.tx_done === 1'b1 || bus.busy !== 1'b0) seen++;
      step();
    end
    tests_run++;
    if (seen !== 0) begin
      tests_failed++;
      $display("FAIL midrst_no_done: got %0d done/busy cycles, expected 0", seen);
    end

    start_pkt(f, to);
    bus.tx_valid = 1'b0;
    capture(T + 1, 0, -5, '0);
    count_wire(f, 0, 1, T + 1, bad, first);
    tests_run++;
    if (bad !== 0 || to) begin
      tests_failed++;
      $display("FAIL midrst_next_wire: got %0d bad cycles (first %0d), expected 0", bad, first);
    end
    count_done(1, T + 1, cnt, at);
    tests_run++;
    if (cnt !== 1 || at !== T) begin
      tests_failed++;
      $display("FAIL midrst_next_done: got count=%0d at=%0d, expected count=1 at=%0d", cnt, at, T);
    end
  endtask

  // Checks the bit-time after data bit 39: the parity bit when enabled,
  // otherwise the first guard bit-time.
  task automatic test_parity();
    logic [39:0] dv [2];
    logic        pbit [2];
    bit to;
    int bad, first, cnt, at;
    dv[0] = 40'h00_0000_0007;  // three ones: parity 1
    dv[1] = 40'h00_0000_0003;  // two ones: parity 0
    pbit[0] = 1'b1;
    pbit[1] = (P == 1) ? 1'b0 : 1'b1;
    for (int i = 0; i < 2; i++) begin
      start_pkt(dv[i], to);
      bus.tx_valid = 1'b0;
      capture(T + 1, 0, -5, '0);
      tests_run++;
      if (w_q[166] !== pbit[i] || to) begin
        tests_failed++;
        $display("FAIL parity_bit[%0d]: got %b, expected %b", i, w_q[166], pbit[i]);
      end
      count_wire(dv[i], 0, 1, T + 1, bad, first);
      tests_run++;
      if (bad !== 0) begin
        tests_failed++;
        $display("FAIL parity_wire[%0d]: got %0d bad cycles (first %0d), expected 0", i, bad, first);
      end
      count_done(1, T + 1, cnt, at);
      tests_run++;
      if (cnt !== 1 || at !== T) begin
        tests_failed++;
        $display("FAIL parity_done[%0d]: got count=%0d at=%0d, expected count=1 at=%0d", i, cnt, at, T);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_busy();
    test_mid_reset();
    test_parity();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
